// File: rtl/width_serializer.sv
// ============================================================================
// width_serializer: splits width_p-bit words into out_width_p chunks, LSB first.
// Optional one-word prefetch when WIDTH_SERIALIZER_PREFETCH_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module width_serializer #(
  parameter int width_p     = 32,
  parameter int out_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [out_width_p-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   last_o
);

  localparam int RATIO = width_p / out_width_p;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  if (width_p % out_width_p != 0) begin : g_width_check
    $error("width_serializer: width_p must be a multiple of out_width_p");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [width_p-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [width_p-1:0] shift_next;
  logic               accept;
  logic               beat;

  // The word shifts right on every beat, so the current chunk is always the low slice.
  if (RATIO > 1) begin : g_shift
    assign shift_next = {{out_width_p{1'b0}}, shift_q[width_p-1:out_width_p]};
  end else begin : g_no_shift
    assign shift_next = '0;
  end

  assign data_o  = shift_q[out_width_p-1:0];
  assign valid_o = (state_q == SEND);
  assign last_o  = valid_o && (cnt_q == LAST_CNT);
  assign accept  = valid_i && ready_o;
  assign beat    = valid_o && ready_i;

`ifdef WIDTH_SERIALIZER_PREFETCH_EN
  logic [width_p-1:0] hold_q, hold_d;
  logic               hold_full_q, hold_full_d;

  assign ready_o = !hold_full_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = data_i;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat && last_o) begin
          cnt_d = '0;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            shift_d = data_i;
          end else begin
            shift_d = shift_next;
            state_d = IDLE;
          end
        end else begin
          if (beat) begin
            shift_d = shift_next;
            cnt_d   = cnt_q + CNT_W'(1);
          end
          if (accept) begin
            hold_d      = data_i;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end
`else
  assign ready_o = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = data_i;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat) begin
          shift_d = shift_next;
          if (last_o) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_width_serializer.sv
// ============================================================================
// tb_width_serializer: scoreboard bench for width_serializer (32->8 and 32->32).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_width_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] d_i;
  logic        v_i, r_o, v_o, rdy, l_o;
  logic [7:0]  d_o;

  logic [31:0] d1_i, d1_o;
  logic        v1_i, r1_o, v1_o, rdy1, l1_o;

  width_serializer #(.width_p(32), .out_width_p(8)) dut (
    .clk_i(clk), .reset_i(rst), .data_i(d_i), .valid_i(v_i), .ready_o(r_o),
    .data_o(d_o), .valid_o(v_o), .ready_i(rdy), .last_o(l_o)
  );

  width_serializer #(.width_p(32), .out_width_p(32)) dut1 (
    .clk_i(clk), .reset_i(rst), .data_i(d1_i), .valid_i(v1_i), .ready_o(r1_o),
    .data_o(d1_o), .valid_o(v1_o), .ready_i(rdy1), .last_o(l1_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected chunks: {last, data}
  logic [8:0]  exp_q[$];
  logic [32:0] exp1_q[$];

  logic       prev_stall, prev_l;
  logic [7:0] prev_d;
  logic       prev_stall1;
  logic [31:0] prev_d1;
  int cyc = 0;
  bit tput_on = 0;
  int tput_beats = 0, first_cyc = 0, last_cyc = 0;

  always @(negedge clk) begin
    logic [8:0]  e;
    logic [32:0] e1;
    cyc++;
    if (rst) begin
      exp_q.delete();
      exp1_q.delete();
      prev_stall  = 1'b0;
      prev_stall1 = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, v_o}, 32'd1);
        chk("stall_data", {24'd0, d_o}, {24'd0, prev_d});
        chk("stall_last", {31'd0, l_o}, {31'd0, prev_l});
      end
`ifndef WIDTH_SERIALIZER_PREFETCH_EN
      chk("ready_vs_valid", {31'd0, r_o}, {31'd0, !v_o});
`endif
      if (v_i && r_o)
        for (int k = 0; k < 4; k++)
          exp_q.push_back({(k == 3), 8'((d_i >> (8 * k)) & 32'hFF)});
      if (v_o && rdy) begin
        if (tput_on) begin
          if (tput_beats == 0) first_cyc = cyc;
          last_cyc = cyc;
          tput_beats++;
        end
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_chunk: got %h expected none", d_o);
        end else begin
          e = exp_q.pop_front();
          chk("chunk_data", {24'd0, d_o}, {24'd0, e[7:0]});
          chk("chunk_last", {31'd0, l_o}, {31'd0, e[8]});
        end
      end
      prev_stall = v_o && !rdy;
      prev_d     = d_o;
      prev_l     = l_o;

      if (prev_stall1) begin
        chk("r1_stall_valid", {31'd0, v1_o}, 32'd1);
        chk("r1_stall_data", d1_o, prev_d1);
      end
      if (v1_i && r1_o) exp1_q.push_back({1'b1, d1_i});
      if (v1_o && rdy1) begin
        if (exp1_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL r1_unexpected_word: got %h expected none", d1_o);
        end else begin
          e1 = exp1_q.pop_front();
          chk("r1_data", d1_o, e1[31:0]);
          chk("r1_last", {31'd0, l1_o}, {31'd0, e1[32]});
        end
      end
      prev_stall1 = v1_o && !rdy1;
      prev_d1     = d1_o;
    end
  end

  // ready modes: 0 = held by main, 1 = random, 2 = toggle each cycle
  int mode = 0;
  always @(posedge clk) begin
    #2;
    if (mode == 1) begin
      rdy  = 1'($urandom_range(0, 1));
      rdy1 = 1'($urandom_range(0, 1));
    end else if (mode == 2) begin
      rdy = ~rdy;
    end
  end

  task automatic send_word(input logic [31:0] w);
    bit acc = 0;
    v_i = 1'b1;
    d_i = w;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = r_o && !rst;
      @(posedge clk);
      #1;
    end
    v_i = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no accept expected accept of %h", w);
    end
  endtask

  task automatic send_word1(input logic [31:0] w);
    bit acc = 0;
    v1_i = 1'b1;
    d1_i = w;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = r1_o && !rst;
      @(posedge clk);
      #1;
    end
    v1_i = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL r1_accept_timeout: got no accept expected accept of %h", w);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (t >= 1000) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size() + exp1_q.size());
    end
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    v_i = 1'b0; d_i = '0; rdy = 1'b0;
    v1_i = 1'b0; d1_i = '0; rdy1 = 1'b0;

    // Reset state held for 10 cycles
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("rst_valid", {31'd0, v_o}, 32'd0);
      chk("rst_last", {31'd0, l_o}, 32'd0);
      chk("rst_ready", {31'd0, r_o}, 32'd1);
      chk("rst_data", {24'd0, d_o}, 32'd0);
      chk("rst1_ready", {31'd0, r1_o}, 32'd1);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // One word at full rate: first chunk the cycle after accept, LSB first
    rdy = 1'b1;
    w = 32'hDDCC_BBAA;
    send_word(w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_valid", {31'd0, v_o}, 32'd1);
      chk("t2_data", {24'd0, d_o}, (w >> (8 * k)) & 32'hFF);
      chk("t2_last", {31'd0, l_o}, {31'd0, (k == 3)});
    end
    @(posedge clk);
    #1;

    // Toggling ready_i
    mode = 2;
    send_word(32'h0403_0201);
    drain();
    mode = 0;
    rdy = 1'b1;
    @(posedge clk);
    #1;

    // Continuous stream with ready_i=1, throughput check
    tput_on = 1;
    tput_beats = 0;
    for (int i = 0; i < 64; i++) send_word($urandom);
    drain();
    tput_on = 0;
    chk("tput_beats", tput_beats, 32'd256);
`ifdef WIDTH_SERIALIZER_PREFETCH_EN
    chk("tput_span", last_cyc - first_cyc + 1, 32'd256);
`else
    chk("tput_span", last_cyc - first_cyc + 1, 32'd319);
`endif

    // Reset in the middle of a word discards the remnant
    @(posedge clk);
    #1;
    send_word(32'h1122_3344);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, v_o}, 32'd0);
    chk("midrst_ready", {31'd0, r_o}, 32'd1);
    chk("midrst_last", {31'd0, l_o}, 32'd0);
    @(posedge clk);
    #1;
    send_word(32'hA5A5_0F0F);
    @(negedge clk);
    chk("midrst_first", {24'd0, d_o}, 32'h0F);
    drain();

    // Random ready, random gaps
    mode = 1;
    for (int i = 0; i < 40; i++) begin
      send_word($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    // ratio == 1 instance
    send_word1(32'h0000_0001);
    send_word1(32'hCAFE_F00D);
    send_word1(32'h8000_0000);
    for (int i = 0; i < 8; i++) send_word1($urandom);
    drain();

    chk("queue_empty", exp_q.size() + exp1_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
